// File: rtl/tri_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tri_input_debounce
//  Purpose  : Conditions three raw asynchronous lines (a, b, c) for the
//             downstream three-input combinational stage. Each line is
//             synchronised, then debounced independently. The block presents
//             clean registered levels and a one-cycle change strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SYNC_STAGES   : synchroniser flops per line (2..4)
//    STABLE_CYCLES : consecutive enabled samples a new level must hold (1..255)
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-high reset
//    raw_a/b/c  in   raw asynchronous input lines
//    sample_en  in   sampling tick; debounce counters advance only when high
//    a/b/c      out  debounced levels, registered
//    changed    out  one-cycle pulse in the cycle a/b/c first show a new value
//    busy       out  high while any channel has a nonzero pending count
//    glitch_cnt out  [7:0] saturating count of enabled edges with at least one
//                    aborted pending change (only with TRI_DEBOUNCE_GLITCH_CNT_EN)
//  Optional feature macro: TRI_DEBOUNCE_GLITCH_CNT_EN
// ============================================================================
module tri_input_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic       raw_c,
    input  logic       sample_en,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       changed,
`ifdef TRI_DEBOUNCE_GLITCH_CNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       busy
);

    localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
    // Count value at which the next disagreeing sample is the accepting one.
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STABLE_CYCLES - 1);

    logic [2:0] w_raw;
    logic [2:0] w_sync;    // last synchroniser stage per channel
    logic [2:0] r_out;
    logic [2:0] w_upd;     // channel accepts its new level on this edge
    logic [2:0] w_abort;   // channel abandons a nonzero pending count
    logic [2:0] w_busy;
    logic       r_changed;

    assign w_raw = {raw_c, raw_b, raw_a};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_cnt_w-1:0]     r_cnt;

        // Synchroniser shifts every cycle, independent of sample_en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
            end
        end

        assign w_sync[i]  = r_sync[SYNC_STAGES-1];
        assign w_upd[i]   = sample_en && (w_sync[i] != r_out[i]) && (r_cnt == c_last);
        assign w_abort[i] = sample_en && (w_sync[i] == r_out[i]) && (r_cnt != '0);
        assign w_busy[i]  = (r_cnt != '0);

        // Counter is zero whenever the synchronised level matches the output;
        // it only runs while a different level keeps being sampled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= '0;
                r_out[i] <= 1'b0;
            end else if (sample_en) begin
                if (w_sync[i] == r_out[i]) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_last) begin
                    r_out[i] <= w_sync[i];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Strobe rises on the same edge the outputs move, so it coincides with the
    // first cycle that shows the new value; simultaneous updates merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_upd;
        end
    end

`ifdef TRI_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_glitch_cnt <= 8'd0;
        end else if ((|w_abort) && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    // Abort detection only feeds the optional glitch counter.
    logic w_abort_unused;
    assign w_abort_unused = |w_abort;
`endif

    assign a       = r_out[0];
    assign b       = r_out[1];
    assign c       = r_out[2];
    assign changed = r_changed;
    assign busy    = |w_busy;

endmodule
`default_nettype wire

// File: doc/tri_input_debounce.md
Name: tri_input_debounce

Overview:
- Upstream conditioning stage for the three-input combinational logic stage (inputs a, b, c).
- Synchronises three raw, asynchronous, possibly bouncing lines into the clock domain.
- Debounces each line independently and presents clean, registered a, b, c levels.
- Pulses a change strobe so downstream logic and monitors know when the operand set moved.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per line (legal 2..4)
STABLE_CYCLES, 4, consecutive enabled samples a new level must hold before it is accepted (legal 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
raw_a  input  1  raw asynchronous line for a
raw_b  input  1  raw asynchronous line for b
raw_c  input  1  raw asynchronous line for c
sample_en  input  1  sampling tick; counters advance only when high (tie to 1 for every-cycle sampling)
a  output  1  debounced a, registered
b  output  1  debounced b, registered
c  output  1  debounced c, registered
changed  output  1  one-cycle pulse, high in the cycle a/b/c first show a new value
busy  output  1  high while any channel has a nonzero pending count

Behaviour:
- Reset (async assert, sync deassert inside clk domain):
  - all synchroniser flops = 0; a = b = c = 0; changed = 0; busy = 0; all counters = 0.
- Synchroniser: per line, SYNC_STAGES-deep flop chain; last stage is s_x. It runs every cycle regardless of sample_en.
- Per-channel counter: width ceil(log2(STABLE_CYCLES+1)).
- Per-channel states:
  - IDLE: s_x == x, counter = 0.
  - PENDING: s_x != x, counter counting.
- Per clk edge with sample_en = 1, each channel:
  - s_x == x: counter <= 0; state IDLE. This is an abort if the counter was nonzero.
  - s_x != x and counter == STABLE_CYCLES-1: x <= s_x; counter <= 0; state IDLE.
  - s_x != x otherwise: counter <= counter+1; state PENDING.
- sample_en = 0: counters and outputs hold; synchronisers still shift.
- changed:
  - registered; high for exactly the one cycle following an edge in which any of a/b/c updated.
  - Simultaneous updates on several channels produce a single pulse.
- busy: combinational OR of (counter != 0) over the three channels.
- Latency with sample_en tied high: a raw step held steady appears on the output SYNC_STAGES + STABLE_CYCLES cycles after the first clk edge that samples it (default 6).
- STABLE_CYCLES = 1: output follows s_x on the first enabled sample; busy never asserts.
- Bounce shorter than the threshold: the counter clears on return to the old level and the output never moves.
- Level changes again during PENDING (back to the current output): treated as an abort; the next departure restarts the count from 0.
- Reset mid-PENDING: the count is discarded and the outputs return to 0 immediately (asynchronously).
- Channels are fully independent; no cross-channel ordering is guaranteed beyond each channel's own latency.

Optional Feature:
- Macro: TRI_DEBOUNCE_GLITCH_CNT_EN
- When defined:
  - Adds output glitch_cnt [7:0], reset 0.
  - Increments once per enabled edge in which at least one channel aborts with a nonzero counter (simultaneous aborts count once).
  - Saturates at 255; never wraps.
- When undefined:
  - Port and logic are absent.
  - Behaviour is otherwise identical.

Test Plan:
- Reset, then raw_a/b/c = 0 held, sample_en = 1 for 20 cycles -> a=b=c=0, changed never high, busy never high.
- raw_a 0->1 held, defaults -> a rises exactly 6 cycles after the sampling edge; changed high for 1 cycle, coincident with a first reading 1; busy high for the 3 cycles before update.
- raw_b bounces 1 for 2 cycles then 0 (STABLE_CYCLES=4) -> b stays 0, changed stays 0. With TRI_DEBOUNCE_GLITCH_CNT_EN defined, glitch_cnt = 1.
- raw_a and raw_c step to 1 on the same edge -> a and c update on the same edge; exactly one changed pulse.
- sample_en toggled 1,0,1,0..., raw_c step to 1 -> c update delayed to the 4th enabled sample (SYNC_STAGES plus 7 cycles after step); counter holds on disabled cycles.
- Assert rst while channel a has counter = 2 with a = 1 from an earlier update -> a = 0, busy = 0, counter = 0 immediately. After release with raw_a still 1, a returns to 1 after 6 cycles.
